// File: rtl/fetch_pc_unit.sv
// Instruction fetch stage: owns the fetch PC, issues in-order requests to
// instruction memory, tags each request with its PC, and buffers returned
// words as {pc, instr} pairs for decode. Responses belonging to requests made
// stale by a redirect are counted off and discarded.
// Optional: define FETCH_PERF_EN to add perf_redirects / perf_bubbles counters.
module fetch_pc_unit #(
  parameter int               WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0,
  parameter int               DEPTH    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_pc,
  output logic [WIDTH-1:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]      perf_redirects,
  output logic [31:0]      perf_bubbles
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW:0] DEPTH_W = (CW+1)'(DEPTH);

  typedef enum logic {FETCH = 1'b0, FLUSH = 1'b1} state_t;

  state_t           state, state_next;
  logic [WIDTH-1:0] pc;
  logic [CW-1:0]    outstanding, count, drop_cnt, drop_next;
  logic [AW-1:0]    head, tail, pq_head, pq_tail;
  logic [WIDTH-1:0] pcq       [DEPTH];
  logic [WIDTH-1:0] buf_pc    [DEPTH];
  logic [WIDTH-1:0] buf_instr [DEPTH];
  logic             credit, req_fire, push, pop;

  assign imem_req_addr = pc;
  assign out_valid     = (count != '0);
  assign out_pc        = out_valid ? buf_pc[head]    : '0;
  assign out_instr     = out_valid ? buf_instr[head] : '0;

  // Buffered words plus words still in flight may never exceed the buffer,
  // so every response in FETCH is guaranteed a slot.
  assign credit   = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_W;
  assign req_fire = imem_req_valid & imem_req_ready;
  assign pop      = out_valid & out_ready;
  // Only live responses are kept; a response coinciding with a redirect is stale.
  assign push     = imem_rsp_valid & (state == FETCH) & ~redirect_valid;

  // Next-state, drop counter and request-valid decode.
  always_comb begin
    state_next     = state;
    drop_next      = drop_cnt;
    imem_req_valid = 1'b0;
    if (rst_n && state == FETCH && !redirect_valid && credit)
      imem_req_valid = 1'b1;
    if (redirect_valid) begin
      // Everything in flight is now stale; one arriving this cycle is dropped here.
      drop_next  = outstanding - CW'(imem_rsp_valid);
      state_next = (drop_next != '0) ? FLUSH : FETCH;
    end else if (state == FLUSH && imem_rsp_valid) begin
      drop_next  = drop_cnt - CW'(1);
      state_next = (drop_next != '0) ? FLUSH : FETCH;
    end
  end

  // State register and stale-response counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= FETCH;
      drop_cnt <= '0;
    end else begin
      state    <= state_next;
      drop_cnt <= drop_next;
    end
  end

  // PC, in-flight count and queue pointers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      count       <= '0;
      head        <= '0;
      tail        <= '0;
      pq_head     <= '0;
      pq_tail     <= '0;
    end else begin
      outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
      if (redirect_valid) begin
        // Stale requests are tracked only by drop_cnt, so the PC queue restarts too.
        pc      <= redirect_pc;
        count   <= '0;
        head    <= '0;
        tail    <= '0;
        pq_head <= '0;
        pq_tail <= '0;
      end else begin
        if (req_fire) begin
          pc      <= pc + WIDTH'(4);
          pq_tail <= pq_tail + AW'(1);
        end
        if (push) begin
          tail    <= tail + AW'(1);
          pq_head <= pq_head + AW'(1);
        end
        if (pop)
          head <= head + AW'(1);
        count <= count + CW'(push) - CW'(pop);
      end
    end
  end

  // Storage: request PCs wait in pcq until their word returns, then move with it.
  always_ff @(posedge clk) begin
    if (req_fire)
      pcq[pq_tail] <= pc;
    if (push) begin
      buf_pc[tail]    <= pcq[pq_head];
      buf_instr[tail] <= imem_rsp_data;
    end
  end

`ifdef FETCH_PERF_EN
  // Redirect and decode-starvation counters, free-running with wrap.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perf_redirects <= '0;
      perf_bubbles   <= '0;
    end else begin
      perf_redirects <= perf_redirects + 32'(redirect_valid);
      perf_bubbles   <= perf_bubbles + 32'(out_ready & ~out_valid);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Bench for fetch_pc_unit: directed vector table for the key sequences, then
// randomized traffic against an epoch-tagged memory/stream model.
module tb_fetch_pc_unit;
  localparam int          DEPTH    = 2;
  localparam logic [31:0] RESET_PC = 32'h0;

  logic        clk = 1'b0, rst_n = 1'b0, redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_pc, out_instr;

  always #5 clk = ~clk;

  fetch_pc_unit #(.WIDTH(32), .RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_pc(out_pc), .out_instr(out_instr)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    int          epoch;
  } mreq_t;

  typedef struct {
    logic rst, redir; logic [31:0] rpc; logic rqr, ordy; int lat;
    bit chk; logic rv; logic [31:0] addr; logic ov; logic [31:0] opc;
  } vec_t;

  mreq_t       memq[$];
  logic [31:0] outq[$];
  vec_t        tbl[$];
  int          epoch = 0, cyc = 0, last_due = 0, checks = 0, fails = 0;
  logic [31:0] req_pc = RESET_PC;
  bit          mdl_ok = 0;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return (a * 32'h0100_0193) ^ 32'hA5A5_A5A5;
  endfunction

  function automatic vec_t mk(logic rst, logic redir, logic [31:0] rpc, logic rqr, logic ordy,
                              int lat, bit c, logic rv, logic [31:0] ad, logic ov, logic [31:0] opc);
    vec_t v;
    v.rst = rst; v.redir = redir; v.rpc = rpc; v.rqr = rqr; v.ordy = ordy; v.lat = lat;
    v.chk = c; v.rv = rv; v.addr = ad; v.ov = ov; v.opc = opc;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, got, exp);
    end
  endtask

  // One clock: drive inputs and memory response, check against model, advance model.
  task automatic step(input logic rst, input logic redir, input logic [31:0] rpc,
                      input logic rqr, input logic ordy, input int lat,
                      output logic s_rv, output logic [31:0] s_addr,
                      output logic s_ov, output logic [31:0] s_opc);
    mreq_t r;
    logic  rsp, exp_rv, acc, mpop;
    int    stale, live, c0, d;
    @(negedge clk);
    rst_n = rst; redirect_valid = redir; redirect_pc = rpc;
    imem_req_ready = rqr; out_ready = ordy;
    if (!rst) memq.delete();
    rsp = 1'b0; stale = 0; live = outq.size();
    r = '{addr: 32'h0, due: 0, epoch: 0};
    foreach (memq[i]) begin
      if (memq[i].epoch != epoch) stale++;
      else live++;
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      rsp = 1'b1;
      r = memq.pop_front();
    end
    imem_rsp_valid = rsp;
    imem_rsp_data  = rsp ? word_of(r.addr) : 32'h0;
    #1;
    s_rv = imem_req_valid; s_addr = imem_req_addr; s_ov = out_valid; s_opc = out_pc;
    if (mdl_ok) begin
      exp_rv = rst && !redir && (stale == 0) && (live < DEPTH);
      chk("req_valid", {31'b0, s_rv}, {31'b0, exp_rv});
      if (s_rv) chk("req_addr", s_addr, req_pc);
      chk("out_valid", {31'b0, s_ov}, {31'b0, outq.size() != 0});
      if (outq.size() != 0) begin
        chk("out_pc", s_opc, outq[0]);
        chk("out_instr", out_instr, word_of(outq[0]));
      end
    end
    acc  = s_rv && rqr;
    mpop = (outq.size() != 0) && ordy;
    c0   = cyc;
    @(posedge clk);
    cyc++;
    if (!rst) begin
      outq.delete();
      epoch++;
      req_pc = RESET_PC;
      mdl_ok = 1;
    end else begin
      if (mpop) void'(outq.pop_front());
      if (rsp && r.epoch == epoch && !redir) outq.push_back(r.addr);
      if (acc) begin
        d = c0 + lat;
        if (d <= last_due) d = last_due + 1;
        last_due = d;
        memq.push_back('{addr: s_addr, due: d, epoch: epoch});
        req_pc = req_pc + 32'd4;
      end
      if (redir) begin
        outq.delete();
        epoch++;
        req_pc = rpc;
      end
    end
  endtask

  initial begin
    logic        rv, ov, r_rst, r_redir, r_rqr, r_ordy;
    logic [31:0] ad, opc, r_rpc;
    int          r_lat;

    // rst redir rpc rqr ordy lat | chk rv addr ov opc
    tbl.push_back(mk(0,0,32'h0,1,1,1, 0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,1,1, 1, 0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h4,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h8,1,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h8,1,32'h4));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'hC,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h10,1,32'h8));
    // decode stalled: credit runs out after two requests
    tbl.push_back(mk(0,0,32'h0,1,0,1, 0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,0,1, 1, 1,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,0,1, 1, 1,32'h4,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,0,1, 1, 0,32'h8,1,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,0,1, 1, 0,32'h8,1,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,0,1, 1, 0,32'h8,1,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h8,1,32'h0));
    // memory not ready for 3 cycles: address holds at 0x8
    tbl.push_back(mk(1,0,32'h0,0,1,1, 1, 1,32'h8,1,32'h4));
    tbl.push_back(mk(1,0,32'h0,0,1,1, 1, 1,32'h8,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,0,1,1, 1, 1,32'h8,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h8,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'hC,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h10,1,32'h8));
    // redirect with two outstanding (latency 3): both dropped
    tbl.push_back(mk(0,0,32'h0,1,1,3, 0, 0,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,3, 1, 1,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,3, 1, 1,32'h4,0,32'h0));
    tbl.push_back(mk(1,1,32'h100,1,1,1, 1, 0,32'h8,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h100,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h100,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h100,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h104,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h108,1,32'h100));
    // redirect with a response in the same cycle, one outstanding
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h108,1,32'h104));
    tbl.push_back(mk(1,1,32'h100,1,1,1, 1, 0,32'h10C,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h100,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h104,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h108,1,32'h100));
    // redirect to top of address space, wrap, then reset while flushing
    tbl.push_back(mk(1,1,32'hFFFF_FFFC,1,1,1, 1, 0,32'h108,1,32'h104));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'hFFFF_FFFC,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,3, 1, 1,32'h0,0,32'h0));
    tbl.push_back(mk(1,1,32'h300,1,1,1, 1, 0,32'h4,1,32'hFFFF_FFFC));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 0,32'h300,0,32'h0));
    tbl.push_back(mk(0,0,32'h0,1,1,1, 1, 0,32'h300,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h0,0,32'h0));
    tbl.push_back(mk(1,0,32'h0,1,1,1, 1, 1,32'h4,0,32'h0));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].redir, tbl[i].rpc, tbl[i].rqr, tbl[i].ordy, tbl[i].lat,
           rv, ad, ov, opc);
      if (tbl[i].chk) begin
        chk($sformatf("row%0d_req_valid", i), {31'b0, rv}, {31'b0, tbl[i].rv});
        chk($sformatf("row%0d_req_addr", i), ad, tbl[i].addr);
        chk($sformatf("row%0d_out_valid", i), {31'b0, ov}, {31'b0, tbl[i].ov});
        if (tbl[i].ov) chk($sformatf("row%0d_out_pc", i), opc, tbl[i].opc);
      end
    end

    // Randomized traffic: variable latency, stalls, redirects, occasional reset.
    step(0, 0, 32'h0, 1, 1, 1, rv, ad, ov, opc);
    for (int n = 0; n < 3000; n++) begin
      r_rst   = ($urandom_range(0, 399) != 0);
      r_redir = ($urandom_range(0, 15) == 0);
      case ($urandom_range(0, 7))
        0:       r_rpc = 32'hFFFF_FFFC;
        1:       r_rpc = $urandom;
        default: r_rpc = $urandom & 32'hFFFF_FFFC;
      endcase
      r_rqr  = ($urandom_range(0, 3) != 0);
      r_ordy = ($urandom_range(0, 2) != 0);
      r_lat  = $urandom_range(1, 4);
      step(r_rst, r_redir, r_rpc, r_rqr, r_ordy, r_lat, rv, ad, ov, opc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
